// File: rtl/issue_scoreboard.sv
// Hazard scoreboard for the even/odd issue pair: per-register writeback countdowns gate RAW/WAW issue.
// Optional macro ISSUE_SCOREBOARD_FWD_EN lets sources read in their writeback cycle (cnt<=1).
module issue_scoreboard #(
   parameter int REG_COUNT  = 128,
   parameter int ADDR_WIDTH = 7,
   parameter int MAX_LAT    = 7,
   parameter int CNT_W      = $clog2(MAX_LAT + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    even_valid,
   input  logic [3*ADDR_WIDTH-1:0] even_src,
   input  logic [2:0]              even_src_vld,
   input  logic [ADDR_WIDTH-1:0]   even_rt,
   input  logic                    even_wr,
   input  logic [CNT_W-1:0]        even_lat,
   input  logic                    odd_valid,
   input  logic [2*ADDR_WIDTH-1:0] odd_src,
   input  logic [1:0]              odd_src_vld,
   input  logic [ADDR_WIDTH-1:0]   odd_rt,
   input  logic                    odd_wr,
   input  logic [CNT_W-1:0]        odd_lat,
   output logic                    even_issue,
   output logic                    odd_issue,
   output logic                    even_stall,
   output logic                    odd_stall,
   output logic                    any_busy
);

   logic [CNT_W-1:0] cnt      [REG_COUNT];
   logic [CNT_W-1:0] cnt_next [REG_COUNT];
   logic             busy_next;
   logic             even_src_ok;
   logic             odd_src_ok;
   logic             pair_hazard;
   logic [CNT_W-1:0] even_eff;
   logic [CNT_W-1:0] odd_eff;

   // With forwarding a result is usable in its writeback cycle; WAW still waits for zero.
   function automatic logic src_ready(input logic [CNT_W-1:0] c);
`ifdef ISSUE_SCOREBOARD_FWD_EN
      return c <= CNT_W'(1);
`else
      return c == '0;
`endif
   endfunction

   function automatic logic [CNT_W-1:0] eff_lat(input logic [CNT_W-1:0] lat);
      if (lat == '0)
         return CNT_W'(1);
      if (int'(lat) > MAX_LAT)
         return CNT_W'(MAX_LAT);
      return lat;
   endfunction

   always_comb begin
      even_src_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (even_src_vld[i] && !src_ready(cnt[even_src[i*ADDR_WIDTH +: ADDR_WIDTH]]))
            even_src_ok = 1'b0;
      end
      odd_src_ok = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (odd_src_vld[i] && !src_ready(cnt[odd_src[i*ADDR_WIDTH +: ADDR_WIDTH]]))
            odd_src_ok = 1'b0;
      end
      // No same-cycle bypass between the pair, so any odd use of even_rt must wait.
      pair_hazard = 1'b0;
      if (even_valid && even_wr) begin
         for (int i = 0; i < 2; i++) begin
            if (odd_src_vld[i] && (odd_src[i*ADDR_WIDTH +: ADDR_WIDTH] == even_rt))
               pair_hazard = 1'b1;
         end
         if (odd_wr && (odd_rt == even_rt))
            pair_hazard = 1'b1;
      end
   end

   assign even_issue = ~reset & even_valid & ~flush & even_src_ok
                     & (~even_wr | (cnt[even_rt] == '0));
   assign odd_issue  = ~reset & odd_valid & ~flush & (~even_valid | even_issue) & odd_src_ok
                     & (~odd_wr | (cnt[odd_rt] == '0)) & ~pair_hazard;
   assign even_stall = ~reset & even_valid & ~even_issue;
   assign odd_stall  = ~reset & odd_valid & ~odd_issue;

   assign even_eff = eff_lat(even_lat);
   assign odd_eff  = eff_lat(odd_lat);

   // A fresh load overrides the decrement; the pair hazard keeps the two loads on distinct entries.
   always_comb begin
      busy_next = 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
         cnt_next[i] = (cnt[i] != '0) ? cnt[i] - CNT_W'(1) : '0;
         if (even_issue && even_wr && (even_rt == ADDR_WIDTH'(i)))
            cnt_next[i] = even_eff;
         if (odd_issue && odd_wr && (odd_rt == ADDR_WIDTH'(i)))
            cnt_next[i] = odd_eff;
         if (flush)
            cnt_next[i] = '0;
         busy_next = busy_next | (cnt_next[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++)
            cnt[i] <= '0;
         any_busy <= 1'b0;
      end else begin
         for (int i = 0; i < REG_COUNT; i++)
            cnt[i] <= cnt_next[i];
         any_busy <= busy_next;
      end
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: directed per-cycle vectors push expected outputs, a monitor pops and compares.
module tb_issue_scoreboard;

`ifdef ISSUE_SCOREBOARD_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        even_valid, even_wr, odd_valid, odd_wr;
   logic [20:0] even_src;
   logic [2:0]  even_src_vld, even_lat, odd_lat;
   logic [13:0] odd_src;
   logic [1:0]  odd_src_vld;
   logic [6:0]  even_rt, odd_rt;
   logic        even_issue, odd_issue, even_stall, odd_stall, any_busy;

   // staged slot contents, copied onto the DUT pins just after each rising edge
   logic        s_ev, s_ewr, s_ov, s_owr;
   logic [20:0] s_esrc;
   logic [2:0]  s_evld, s_elat, s_olat;
   logic [13:0] s_osrc;
   logic [1:0]  s_ovld;
   logic [6:0]  s_ert, s_ort;

   typedef struct {
      string      name;
      logic [4:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   issue_scoreboard dut (
      .clk(clk), .reset(reset), .flush(flush),
      .even_valid(even_valid), .even_src(even_src), .even_src_vld(even_src_vld),
      .even_rt(even_rt), .even_wr(even_wr), .even_lat(even_lat),
      .odd_valid(odd_valid), .odd_src(odd_src), .odd_src_vld(odd_src_vld),
      .odd_rt(odd_rt), .odd_wr(odd_wr), .odd_lat(odd_lat),
      .even_issue(even_issue), .odd_issue(odd_issue),
      .even_stall(even_stall), .odd_stall(odd_stall), .any_busy(any_busy)
   );

   task automatic set_even(input logic v, input logic [6:0] ra, input logic [6:0] rb,
                           input logic [6:0] rc, input logic [2:0] vld, input logic [6:0] rt,
                           input logic wr, input logic [2:0] lat);
      s_ev = v; s_esrc = {ra, rb, rc}; s_evld = vld; s_ert = rt; s_ewr = wr; s_elat = lat;
   endtask

   task automatic set_odd(input logic v, input logic [6:0] ra, input logic [6:0] rb,
                          input logic [1:0] vld, input logic [6:0] rt,
                          input logic wr, input logic [2:0] lat);
      s_ov = v; s_osrc = {ra, rb}; s_ovld = vld; s_ort = rt; s_owr = wr; s_olat = lat;
   endtask

   // Drive one cycle of stimulus and queue the outputs it must produce in that cycle.
   task automatic applyStimulus(input string name, input logic rst, input logic fl,
                                input logic x_ei, input logic x_oi, input logic x_busy);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; flush = fl;
      even_valid = s_ev; even_src = s_esrc; even_src_vld = s_evld;
      even_rt = s_ert; even_wr = s_ewr; even_lat = s_elat;
      odd_valid = s_ov; odd_src = s_osrc; odd_src_vld = s_ovld;
      odd_rt = s_ort; odd_wr = s_owr; odd_lat = s_olat;
      e.name = name;
      e.val  = {x_ei, x_oi, ~rst & s_ev & ~x_ei, ~rst & s_ov & ~x_oi, x_busy};
      sb.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      logic [4:0] act;
      act = {even_issue, odd_issue, even_stall, odd_stall, any_busy};
      n_checks++;
      if (act !== e.val) begin
         n_fail++;
         $display("[TB] FAIL %s: {ei,oi,es,os,busy} actual=%b required=%b", e.name, act, e.val);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0)
            checkOutput(sb.pop_front());
      end
   end

   initial begin
      reset = 1'b1; flush = 1'b0;
      even_valid = 1'b0; even_src = '0; even_src_vld = '0; even_rt = '0; even_wr = 1'b0; even_lat = '0;
      odd_valid = 1'b0; odd_src = '0; odd_src_vld = '0; odd_rt = '0; odd_wr = 1'b0; odd_lat = '0;

      // reset holds issue and stall low even with both slots valid
      set_even(1, 0, 0, 0, 3'b000, 9, 1, 2);
      set_odd(1, 0, 0, 2'b00, 8, 1, 2);
      applyStimulus("reset_hold", 1, 0, 0, 0, 0);

      // write r5 lat 4, then read r5 until it issues
      set_even(1, 0, 0, 0, 3'b000, 5, 1, 4);
      set_odd(0, 0, 0, 2'b00, 0, 0, 0);
      applyStimulus("t1_write_r5", 0, 0, 1, 0, 0);
      set_even(1, 5, 0, 0, 3'b100, 0, 0, 0);
      for (int k = 0; k < 3; k++)
         applyStimulus("t1_raw_stall", 0, 0, 0, 0, 1);
      applyStimulus("t1_cnt1", 0, 0, FWD, 0, 1);
      applyStimulus("t1_issue", 0, 0, 1, 0, 0);

      // even writes r10 while odd reads r10 in the same pair
      set_even(1, 0, 0, 0, 3'b000, 10, 1, 2);
      set_odd(1, 10, 0, 2'b10, 0, 0, 0);
      applyStimulus("t2_pair_hazard", 0, 0, 1, 0, 0);
      set_even(0, 0, 0, 0, 3'b000, 0, 0, 0);
      applyStimulus("t2_odd_cnt2", 0, 0, 0, 0, 1);
      applyStimulus("t2_odd_cnt1", 0, 0, 0, FWD, 1);
      applyStimulus("t2_odd_issue", 0, 0, 0, 1, 0);

      // even blocked on r3 holds back an independent odd
      set_even(1, 0, 0, 0, 3'b000, 3, 1, 3);
      set_odd(0, 0, 0, 2'b00, 0, 0, 0);
      applyStimulus("t3_write_r3", 0, 0, 1, 0, 0);
      set_even(1, 0, 3, 0, 3'b010, 0, 0, 0);
      set_odd(1, 41, 0, 2'b10, 0, 0, 0);
      applyStimulus("t3_in_order_a", 0, 0, 0, 0, 1);
      applyStimulus("t3_in_order_b", 0, 0, 0, 0, 1);
      applyStimulus("t3_cnt1", 0, 0, FWD, FWD, 1);
      applyStimulus("t3_both_issue", 0, 0, 1, 1, 0);

      // flush drops the pending r7 entry
      set_even(1, 0, 0, 0, 3'b000, 7, 1, 6);
      set_odd(0, 0, 0, 2'b00, 0, 0, 0);
      applyStimulus("t4_write_r7", 0, 0, 1, 0, 0);
      set_even(0, 0, 0, 0, 3'b000, 0, 0, 0);
      applyStimulus("t4_idle", 0, 0, 0, 0, 1);
      set_even(1, 1, 0, 0, 3'b100, 0, 0, 0);
      set_odd(1, 2, 0, 2'b10, 0, 0, 0);
      applyStimulus("t4_flush_block", 0, 1, 0, 0, 1);
      set_even(1, 7, 0, 0, 3'b100, 0, 0, 0);
      set_odd(0, 0, 0, 2'b00, 0, 0, 0);
      applyStimulus("t4_after_flush", 0, 0, 1, 0, 0);

      // odd WAW on pending r20 waits for cnt==0 in both configurations
      set_even(1, 0, 0, 0, 3'b000, 20, 1, 3);
      applyStimulus("t5_write_r20", 0, 0, 1, 0, 0);
      set_even(0, 0, 0, 0, 3'b000, 0, 0, 0);
      set_odd(1, 0, 0, 2'b00, 20, 1, 2);
      for (int k = 0; k < 3; k++)
         applyStimulus("t5_waw_stall", 0, 0, 0, 0, 1);
      applyStimulus("t5_waw_issue", 0, 0, 0, 1, 0);
      set_odd(0, 0, 0, 2'b00, 0, 0, 0);
      applyStimulus("t5_drain_2", 0, 0, 0, 0, 1);
      applyStimulus("t5_drain_1", 0, 0, 0, 0, 1);
      applyStimulus("t5_drained", 0, 0, 0, 0, 0);

      // latency 0 behaves as 1
      set_even(1, 0, 0, 0, 3'b000, 30, 1, 0);
      applyStimulus("t6_lat0_write", 0, 0, 1, 0, 0);
      set_even(1, 30, 0, 0, 3'b100, 0, 0, 0);
      applyStimulus("t6_lat0_cnt1", 0, 0, FWD, 0, 1);
      applyStimulus("t6_lat0_ready", 0, 0, 1, 0, 0);

      // maximum latency counts down from 7
      set_even(1, 0, 0, 0, 3'b000, 31, 1, 7);
      applyStimulus("t6_lat7_write", 0, 0, 1, 0, 0);
      set_even(1, 0, 0, 31, 3'b001, 0, 0, 0);
      for (int k = 0; k < 7; k++)
         applyStimulus("t6_lat7_count", 0, 0, FWD && (k == 6), 0, 1);
      applyStimulus("t6_lat7_ready", 0, 0, 1, 0, 0);

      // reset mid-countdown clears the r50 entry
      set_even(1, 0, 0, 0, 3'b000, 50, 1, 5);
      applyStimulus("t6_write_r50", 0, 0, 1, 0, 0);
      set_even(1, 50, 0, 0, 3'b100, 0, 0, 0);
      set_odd(1, 0, 0, 2'b00, 0, 0, 0);
      applyStimulus("t6_mid_reset", 1, 0, 0, 0, 1);
      set_odd(0, 0, 0, 2'b00, 0, 0, 0);
      applyStimulus("t6_after_reset", 0, 0, 1, 0, 0);

      for (int k = 0; k < 4 && sb.size() > 0; k++)
         @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL drain: pending=%0d required=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
